// File: rtl/vector_sweep_sequencer.sv
// Exhaustive input sweeper: drives every vector, waits a settle time, compares dut_y against ref_y.
// Define SWEEP_CONTINUE_ON_FAIL_EN to check all vectors instead of stopping at the first mismatch.
module vector_sweep_sequencer #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_y,
  input  logic            ref_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_dut,
  output logic            fail_ref,
  output logic [N_IN:0]   err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(SETTLE_EFF) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

`ifdef SWEEP_CONTINUE_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b0;
`else
  localparam bit STOP_ON_FAIL = 1'b1;
`endif

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;
  logic             last_vec;
  logic [N_IN:0]    err_inc;

  // NOTE: case inequality makes an X/Z on dut_y count as a miss in simulation; hardware sees a plain compare.
  assign mismatch = (dut_y !== ref_y);
  assign last_vec = (vec_out == {N_IN{1'b1}});
  assign err_inc  = err_cnt + {{N_IN{1'b0}}, mismatch};

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      fail_dut   <= 1'b0;
      fail_ref   <= 1'b0;
      err_cnt    <= '0;
    end else if (abort) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
      fail_dut   <= 1'b0;
      fail_ref   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= CNT_LOAD;
            vec_out    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_dut   <= 1'b0;
            fail_ref   <= 1'b0;
            err_cnt    <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_inc;
            // Only the first miss of a sweep is recorded.
            if (err_cnt == '0) begin
              fail_vec <= vec_out;
              fail_dut <= dut_y;
              fail_ref <= ref_y;
            end
          end
          if ((mismatch && STOP_ON_FAIL) || last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_inc == '0);
          end else begin
            state      <= SETTLE;
            settle_cnt <= CNT_LOAD;
            vec_out    <= vec_out + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sweep_sequencer.sv
// Directed bench for vector_sweep_sequencer (N_IN=3, SETTLE_CYCLES=2) with a NAND3 golden model.
module tb_vector_sweep_sequencer;

`ifdef SWEEP_CONTINUE_ON_FAIL_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] vec_out;
  logic       dut_y, ref_y;
  logic       busy, done, pass;
  logic [2:0] fail_vec;
  logic       fail_dut, fail_ref;
  logic [3:0] err_cnt;

  logic [7:0] bad_mask = 8'h00;
  logic       x_mode   = 1'b0;
  logic       x_val    = 1'bx;

  int checks = 0;
  int errors = 0;

  // NAND3 golden; the user side is inverted on vectors flagged in bad_mask, or forced unknown.
  assign dut_y = x_mode ? x_val : ((~&vec_out) ^ bad_mask[vec_out]);
  assign ref_y = x_mode ? ((dut_y === 1'b0) ? 1'b1 : 1'b0) : ~&vec_out;

  vector_sweep_sequencer #(.N_IN(3), .SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .vec_out  (vec_out),
    .dut_y    (dut_y),
    .ref_y    (ref_y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_vec (fail_vec),
    .fail_dut (fail_dut),
    .fail_ref (fail_ref),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_edge(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({vec_out, busy, done, pass, fail_vec, fail_dut, fail_ref, err_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_vals: got %b expected %b",
               {vec_out, busy, done, pass, fail_vec, fail_dut, fail_ref, err_cnt}, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({busy, done, vec_out} !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", {busy, done, vec_out}, 5'd0);
    end
  endtask

  task automatic test_clean_sweep(input string tag);
    logic [2:0] exp_vec;
    bad_mask = 8'h00;
    x_mode   = 1'b0;
    drive_edge(1'b1, 1'b0);
    checks++;
    if ({busy, done, vec_out} !== 5'b10_000) begin
      errors++;
      $display("FAIL %s_e0: got %b expected %b", tag, {busy, done, vec_out}, 5'b10_000);
    end
    for (int e = 1; e <= 24; e++) begin
      step(1);
      exp_vec = (e < 24) ? 3'(e / 3) : 3'd7;
      checks++;
      if ({busy, done, vec_out} !== {(e < 24), (e == 24), exp_vec}) begin
        errors++;
        $display("FAIL %s_e%0d: busy/done/vec got %b expected %b", tag, e,
                 {busy, done, vec_out}, {(e < 24), (e == 24), exp_vec});
      end
    end
    checks++;
    if ({pass, fail_vec, fail_dut, fail_ref, err_cnt} !== {1'b1, 9'd0}) begin
      errors++;
      $display("FAIL %s_result: got %b expected %b", tag,
               {pass, fail_vec, fail_dut, fail_ref, err_cnt}, {1'b1, 9'd0});
    end
    step(3);
    checks++;
    if ({done, vec_out} !== 4'b1_111) begin
      errors++;
      $display("FAIL %s_hold: got %b expected %b", tag, {done, vec_out}, 4'b1_111);
    end
  endtask

  // Runs one sweep that must end at done_edge; fail_dut/fail_ref compared only when chk_pins is set.
  task automatic test_fail_sweep(input string tag, input logic [7:0] mask, input logic xm,
                                 input int done_edge, input int exp_err, input logic [2:0] exp_vec,
                                 input logic chk_pins);
    logic exp_ref;
    bad_mask = mask;
    x_mode   = xm;
    drive_edge(1'b1, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: done got %b expected 0", tag, done);
    end
    for (int e = 1; e <= done_edge; e++) begin
      step(1);
      if (e >= done_edge - 1) begin
        checks++;
        if ({done, busy} !== {(e == done_edge), (e != done_edge)}) begin
          errors++;
          $display("FAIL %s_e%0d: done/busy got %b expected %b", tag, e,
                   {done, busy}, {(e == done_edge), (e != done_edge)});
        end
      end
    end
    checks++;
    if ({pass, fail_vec, err_cnt} !== {1'b0, exp_vec, 4'(exp_err)}) begin
      errors++;
      $display("FAIL %s_result: pass/vec/err got %b expected %b", tag,
               {pass, fail_vec, err_cnt}, {1'b0, exp_vec, 4'(exp_err)});
    end
    if (chk_pins) begin
      exp_ref = ~&exp_vec;
      checks++;
      if ({fail_dut, fail_ref} !== {~exp_ref, exp_ref}) begin
        errors++;
        $display("FAIL %s_pins: dut/ref got %b expected %b", tag,
                 {fail_dut, fail_ref}, {~exp_ref, exp_ref});
      end
    end
    x_mode = 1'b0;
  endtask

  task automatic test_abort;
    bad_mask = 8'h00;
    drive_edge(1'b1, 1'b0);
    step(5);
    drive_edge(1'b1, 1'b0);
    checks++;
    if ({busy, vec_out} !== 4'b1_010) begin
      errors++;
      $display("FAIL start_busy_ignored: got %b expected %b", {busy, vec_out}, 4'b1_010);
    end
    step(6);
    checks++;
    if ({busy, vec_out} !== 4'b1_100) begin
      errors++;
      $display("FAIL abort_pre: got %b expected %b", {busy, vec_out}, 4'b1_100);
    end
    drive_edge(1'b0, 1'b1);
    checks++;
    if ({busy, done, pass, vec_out} !== 6'd0) begin
      errors++;
      $display("FAIL abort_mid: got %b expected %b", {busy, done, pass, vec_out}, 6'd0);
    end
    step(4);
    checks++;
    if ({busy, done, vec_out} !== 5'd0) begin
      errors++;
      $display("FAIL abort_stays_idle: got %b expected %b", {busy, done, vec_out}, 5'd0);
    end
    test_fail_sweep("pre_abort", 8'h04, 1'b0, CONT ? 24 : 9, 1, 3'd2, 1'b1);
    drive_edge(1'b0, 1'b1);
    checks++;
    if ({busy, done, pass, vec_out, fail_vec, fail_dut, fail_ref, err_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL abort_done_clear: got %b expected %b",
               {busy, done, pass, vec_out, fail_vec, fail_dut, fail_ref, err_cnt}, 15'd0);
    end
    drive_edge(1'b1, 1'b1);
    step(2);
    checks++;
    if ({busy, done, vec_out} !== 5'd0) begin
      errors++;
      $display("FAIL start_abort_same: got %b expected %b", {busy, done, vec_out}, 5'd0);
    end
  endtask

  task automatic test_async_reset;
    bad_mask = 8'h00;
    drive_edge(1'b1, 1'b0);
    step(4);
    checks++;
    if ({busy, vec_out} !== 4'b1_001) begin
      errors++;
      $display("FAIL arst_pre: got %b expected %b", {busy, vec_out}, 4'b1_001);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_out, busy, done, pass, fail_vec, fail_dut, fail_ref, err_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL arst_immediate: got %b expected %b",
               {vec_out, busy, done, pass, fail_vec, fail_dut, fail_ref, err_cnt}, 15'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({busy, done, vec_out} !== 5'd0) begin
      errors++;
      $display("FAIL arst_idle: got %b expected %b", {busy, done, vec_out}, 5'd0);
    end
    test_clean_sweep("post_rst");
  endtask

  initial begin
    test_reset();
    test_clean_sweep("clean");
    test_fail_sweep("one_bad", 8'h04, 1'b0, CONT ? 24 : 9, 1, 3'd2, 1'b1);
    test_fail_sweep("two_bad", 8'h44, 1'b0, CONT ? 24 : 9, CONT ? 2 : 1, 3'd2, 1'b1);
    test_fail_sweep("x_dut", 8'h00, 1'b1, CONT ? 24 : 3, CONT ? 8 : 1, 3'd0, 1'b0);
    test_clean_sweep("restart");
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sweep_sequencer.md
Name: vector_sweep_sequencer

Overview:
Self-checking stimulus sequencer for small combinational exercise blocks such as the 3-input gates graded by the judge. On `start` it drives every input combination, 0 to 2^N_IN-1, onto a shared vector bus that feeds both the user module and the golden module. It waits a programmable settle time, then compares the two outputs. It reports pass/fail, the first failing vector and both observed outputs. It replaces the hand-unrolled per-vector checks in grading benches with one reusable block.

Parameters:
- N_IN, 3, number of DUT inputs; the sweep covers 2^N_IN vectors. Legal range 1..16.
- SETTLE_CYCLES, 2, cycles a vector is held before sampling. Minimum 1; 0 is treated as 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low; returns every register to its reset value immediately.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns to IDLE without asserting done.
- vec_out  out  N_IN  stimulus bus to the user and golden modules.
- dut_y  in  1  user module output.
- ref_y  in  1  golden module output.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  level; high in DONE until the next start, abort or reset.
- pass  out  1  valid while done; 1 means all vectors matched.
- fail_vec  out  N_IN  first mismatching vector; valid when done && !pass.
- fail_dut  out  1  dut_y captured at the failing check.
- fail_ref  out  1  ref_y captured at the failing check.
- err_cnt  out  N_IN+1  number of mismatching vectors in the last sweep.

Behaviour:
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, fail_vec=0, fail_dut=0, fail_ref=0, err_cnt=0, settle counter=0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1: clear done, pass, fail_*, err_cnt; set vec_out=0; load the settle counter; go to SETTLE.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to CHECK. vec_out is stable throughout.
- CHECK: stays 1 cycle. Mismatch is defined as dut_y !== ref_y (4-state compare); X or Z on dut_y counts as a mismatch.
  - Match, vector not last: increment vec_out, reload the counter, go to SETTLE.
  - Match, last vector (all ones): go to DONE with pass = (err_cnt==0).
  - Mismatch: increment err_cnt; on the first mismatch only, capture fail_vec, fail_dut and fail_ref; then follow the optional-feature rule.
- Cost per vector: SETTLE_CYCLES+1 cycles. A clean sweep enters DONE 2^N_IN*(SETTLE_CYCLES+1) rising edges after the edge that samples start.
- vec_out is held at its final value in DONE; it is reset to 0 only by a new start, abort or reset.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- abort in any state: go to IDLE next edge, vec_out=0, done=0, pass=0. err_cnt and fail_* are cleared.
- rst_n low mid-sweep: immediate return to reset values; no partial result is retained.
- Wrap-around: vec_out never wraps past all-ones; the last-vector test uses the compare vec_out == {N_IN{1'b1}}.
- err_cnt width N_IN+1 holds 2^N_IN without overflow.

Optional Feature:
- Macro: SWEEP_CONTINUE_ON_FAIL_EN.
- Undefined (default): the first mismatch ends the sweep. The next state is DONE with pass=0 and err_cnt=1.
- Defined: a mismatch does not stop the sweep; all 2^N_IN vectors are checked. fail_* still hold the first mismatch. err_cnt holds the total mismatch count. Final pass = (err_cnt==0).

Test Plan:
- Defaults, ref_y=dut_y=~&vec_out (matching NAND3), start pulse at edge 0 -> busy high edges 1-24, vec_out steps 0..7 every 3 cycles, done=1 and pass=1 after edge 24, err_cnt=0.
- dut_y forced wrong for vec 3'b010 only, macro off -> DONE after edge 9, pass=0, fail_vec=3'b010, fail_dut=~fail_ref, err_cnt=1.
- Same stimulus with SWEEP_CONTINUE_ON_FAIL_EN; dut_y wrong for vec 2 and vec 6 -> DONE after edge 24, fail_vec=2, err_cnt=2, pass=0.
- dut_y=1'bx for all vectors -> first check fails: fail_vec=0, pass=0.
- Mid-sweep (vec_out=4): pulse abort -> IDLE next edge, vec_out=0, done=0; start during busy earlier -> no restart; start in the same cycle as abort -> IDLE.
- rst_n dropped asynchronously mid-SETTLE, between clock edges -> all outputs at reset values before the next edge; a new start after release runs a full clean sweep.
